// File: rtl/ifetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package ifetch_pkg;

  localparam int unsigned PC_STEP      = 4;
  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned ADDR_W_DEF   = 10;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Word index of a byte address; callers keep the low ADDR_W bits so fetches wrap.
  function automatic logic [63:0] word_index(input logic [63:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/ifetch_pipe_imem_sync.sv
// Single-clock instruction RAM: one write port, one enabled read port with a
// read-first registered output.
module imem_sync #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto block RAM; only the read register resets.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // NOTE: non-blocking assignments make a same-word read see the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ifetch_pipe.sv
// Instruction-fetch stage: PC, request registers and next-address mux in front of imem_sync.
// Optional misaligned-redirect fault detection is enabled with IFETCH_MISALIGN_CHK_EN.
module ifetch_pipe
  import ifetch_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter int unsigned      ADDR_W   = ADDR_W_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               imem_we,
  input  logic [ADDR_W-1:0]  imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic               if_valid,
  output logic [XLEN-1:0]    if_pc,
  output logic [XLEN-1:0]    if_npc,
  output logic [INSTR_W-1:0] if_ir
`ifdef IFETCH_MISALIGN_CHK_EN
  ,
  output logic               if_fault
`endif
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0]    r_pc, r_req_pc;
  logic               r_req_valid;
  logic [XLEN-1:0]    w_pc_nxt, w_req_pc_nxt, w_fetch_pc, w_redir_pc;
  logic               w_req_valid_nxt, w_re;
  logic               w_misaligned, w_halt, w_fault_nxt;
  logic [ADDR_W-1:0]  w_raddr;
  logic [INSTR_W-1:0] w_rdata;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic r_fault;
  assign w_redir_pc   = redirect_pc;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign w_halt       = r_fault;
`else
  assign w_redir_pc   = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_misaligned = 1'b0;
  assign w_halt       = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    w_pc_nxt        = r_pc;
    w_req_pc_nxt    = r_req_pc;
    w_req_valid_nxt = r_req_valid;
    w_fetch_pc      = r_pc;
    w_re            = 1'b0;
    w_fault_nxt     = w_halt;
    if (redirect_valid && w_misaligned) begin
      w_req_pc_nxt    = redirect_pc;
      w_req_valid_nxt = 1'b0;
      w_fault_nxt     = 1'b1;
    end else if (redirect_valid) begin
      w_re            = 1'b1;
      w_fetch_pc      = w_redir_pc;
      w_req_pc_nxt    = w_redir_pc;
      w_req_valid_nxt = 1'b1;
      w_pc_nxt        = w_redir_pc + STEP;
      w_fault_nxt     = 1'b0;
    end else if (!stall && !w_halt) begin
      w_re            = 1'b1;
      w_req_pc_nxt    = r_pc;
      w_req_valid_nxt = 1'b1;
      w_pc_nxt        = r_pc + STEP;
    end
  end

  assign w_raddr = ADDR_W'(word_index(64'(w_fetch_pc)));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_req_pc    <= '0;
      r_req_valid <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_req_valid <= w_req_valid_nxt;
    end
  end

`ifdef IFETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fault <= 1'b0;
    else        r_fault <= w_fault_nxt;
  end
  assign if_fault = r_fault;
`endif

  imem_sync #(
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W)
  ) u_imem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (imem_we),
    .i_waddr (imem_waddr),
    .i_wdata (imem_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign if_valid = r_req_valid;
  assign if_pc    = r_req_pc;
  assign if_npc   = r_req_pc + STEP;
  assign if_ir    = w_rdata;

endmodule

// File: tb/tb_ifetch_pipe.sv
// Self-checking bench for ifetch_pipe: a reference fetch model pushes expected
// outputs per driven cycle; they are popped and compared after the edge.
module tb_ifetch_pipe;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 10;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        fault;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, redirect_valid, imem_we;
  logic [XLEN-1:0]   redirect_pc;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              if_valid;
  logic [XLEN-1:0]   if_pc, if_npc;
  logic [31:0]       if_ir;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic              if_fault;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_step   = 0;

  logic [31:0] m_mem [1024];
  logic [31:0] m_pc;
  exp_t        m_out;
  exp_t        sb [$];

  ifetch_pipe #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_npc         (if_npc),
    .if_ir          (if_ir)
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    .if_fault       (if_fault)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %08h want %08h", tag, n_step, obs, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check("if_valid", {31'b0, if_valid}, {31'b0, e.valid});
    check("if_pc",    if_pc,             e.pc);
    check("if_npc",   if_npc,            e.pc + 32'd4);
    check("if_ir",    if_ir,             e.ir);
`ifdef IFETCH_MISALIGN_CHK_EN
    check("if_fault", {31'b0, if_fault}, {31'b0, e.fault});
`endif
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_out = '{valid: 1'b0, pc: 32'h0, ir: 32'h0, fault: 1'b0};
    sb.delete();
  endtask

  task automatic load(input logic [ADDR_W-1:0] wa, input logic [31:0] wd);
    imem_we    = 1'b1;
    imem_waddr = wa;
    imem_wdata = wd;
    m_mem[wa]  = wd;
    @(posedge clk); #1;
    imem_we    = 1'b0;
  endtask

  // One clock of stimulus; the model computes what the outputs must be after the edge.
  task automatic step(input logic st, input logic rv, input logic [31:0] rpc,
                      input logic we, input logic [ADDR_W-1:0] wa, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] ta;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_we        = we;
    imem_waddr     = wa;
    imem_wdata     = wd;
    e  = m_out;
    ta = rpc & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_CHK_EN
    if (rv && rpc[1:0] != 2'b00) begin
      e.valid = 1'b0;
      e.pc    = rpc;
      e.fault = 1'b1;
    end else
`endif
    if (rv) begin
      e.valid = 1'b1;
      e.pc    = ta;
      e.ir    = m_mem[ta[11:2]];
      e.fault = 1'b0;
      m_pc    = ta + 32'd4;
    end else if (!st && !m_out.fault) begin
      e.valid = 1'b1;
      e.pc    = m_pc;
      e.ir    = m_mem[m_pc[11:2]];
      m_pc    = m_pc + 32'd4;
    end
    if (we) m_mem[wa] = wd;
    m_out = e;
    sb.push_back(e);
    @(posedge clk); #1;
    n_step++;
    if (sb.size() == 0) check("sb_empty", 32'd0, 32'd1);
    else check_outputs(sb.pop_front());
    imem_we        = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic run(input logic st, input logic rv, input logic [31:0] rpc);
    step(st, rv, rpc, 1'b0, '0, 32'h0);
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_we        = 1'b0;
    imem_waddr     = '0;
    imem_wdata     = '0;
    model_reset();
    @(posedge clk); #1;

    // Preload while reset is held; the write port is live regardless.
    for (int i = 0; i < 64; i++) load(ADDR_W'(i), 32'h1000_0000 + i);
    for (int i = 1020; i < 1024; i++) load(ADDR_W'(i), 32'h2000_0000 + i);
    check_outputs(m_out);

    rst_n = 1'b1;
    // Sequential fetch 0, 4, 8, then a 3-cycle stall holding 8.
    for (int i = 0; i < 3; i++) run(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) run(1'b1, 1'b0, 32'h0);
    run(1'b0, 1'b0, 32'h0);
    run(1'b0, 1'b0, 32'h0);

    // Redirect overrides a simultaneous stall.
    run(1'b1, 1'b1, 32'h0000_0040);
    run(1'b0, 1'b0, 32'h0);

    // Read-first on a same-cycle write to the word being fetched.
    run(1'b0, 1'b1, 32'h0000_0010);
    step(1'b0, 1'b0, 32'h0, 1'b1, ADDR_W'(5), 32'hDEAD_BEEF);
    run(1'b0, 1'b1, 32'h0000_0014);
    run(1'b0, 1'b0, 32'h0);

    // Index wrap at the top of memory and PC wrap at 2**XLEN.
    run(1'b0, 1'b1, 32'h0000_0FF8);
    run(1'b0, 1'b0, 32'h0);
    run(1'b0, 1'b0, 32'h0);
    run(1'b0, 1'b1, 32'hFFFF_FFFC);
    run(1'b0, 1'b0, 32'h0);

    // Misaligned redirect: faults with the check enabled, aligned down otherwise.
    run(1'b0, 1'b1, 32'h0000_0042);
    for (int i = 0; i < 5; i++) run(1'b0, 1'b0, 32'h0);
    run(1'b0, 1'b1, 32'h0000_0040);
    run(1'b0, 1'b0, 32'h0);

    // Asynchronous reset mid-stream, then a stall on the first post-reset edge.
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(m_out);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(1'b1, 1'b0, 32'h0);
    run(1'b0, 1'b0, 32'h0);
    run(1'b1, 1'b0, 32'h0);
    run(1'b1, 1'b0, 32'h0);
    run(1'b0, 1'b0, 32'h0);

    // Mixed random traffic confined to the preloaded words.
    for (int i = 0; i < 40; i++) begin
      logic        st, rv;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 4) == 0) || (m_pc > 32'h0000_00E0);
      rpc = {25'b0, 5'($urandom_range(0, 31)), 2'b00};
      run(st, rv, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
